// File: rtl/glitch_pkg.sv
// Shared types and widths for the glitch pulse generator and its configuring UART handler.
// Latency: none, this file holds only declarations.
// Backpressure: none.
package glitch_pkg;

    localparam int DELAY_W   = 16;
    localparam int WIDTH_W   = 8;
    localparam int NPULSE_W  = 8;
    localparam int SPACING_W = 16;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW,
        DONE
    } state_t;

    // A spacing of zero still yields one low cycle so that adjacent pulses never merge.
    function automatic logic [CNT_W-1:0] gap_load(input logic [SPACING_W-1:0] sp);
        return (sp == '0) ? '0 : (sp - SPACING_W'(1));
    endfunction

    function automatic logic [CNT_W-1:0] width_load(input logic [WIDTH_W-1:0] w);
        return {{(CNT_W-WIDTH_W){1'b0}}, w} - CNT_W'(1);
    endfunction

endpackage

// File: rtl/glitch_pulse_gen_trigger_sync.sv
// Synchronises an asynchronous trigger pin and emits a one-cycle pulse on its rising edge.
// Latency: pulse is high in the cycle after sample edge E+SYNC_STAGES-1 (E = first high sample).
// Backpressure: none, the pulse is fire-and-forget.
module trigger_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_async,
    output logic trig_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign trig_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Delayed glitch pulse train generator started by a software strobe or an external trigger edge.
// Latency: first pulse delay+1 cycles after the start is sampled; outputs are registered.
// Backpressure: starts arriving outside IDLE/DONE are dropped, never queued.
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int EXT_TRIG_EN = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [WIDTH_W-1:0]   width_i,
    input  logic [NPULSE_W-1:0]  num_pulses_i,
    input  logic [SPACING_W-1:0] pulse_spacing_i,
    input  logic                 pulse_en_i,
    input  logic                 ext_trig_i,
    input  logic                 abort_i,
    output logic                 glitch_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_t               state_q, state_nx;
    logic [CNT_W-1:0]     cnt_q, cnt_nx;
    logic [NPULSE_W-1:0]  npul_q, npul_nx;
    logic [WIDTH_W-1:0]   width_q, width_nx;
    logic [SPACING_W-1:0] space_q, space_nx;
    logic                 ext_evt;
    logic                 start_evt;

    generate
        if (EXT_TRIG_EN != 0) begin : g_ext
            trigger_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_trigger_sync (
                .clk        (clk),
                .rst        (rst),
                .trig_async (ext_trig_i),
                .trig_pulse (ext_evt)
            );
        end else begin : g_no_ext
            logic unused_ext;
            assign unused_ext = ext_trig_i;
            assign ext_evt    = 1'b0;
        end
    endgenerate

    assign start_evt = pulse_en_i | ext_evt;

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        npul_nx  = npul_q;
        width_nx = width_q;
        space_nx = space_q;
        case (state_q)
            IDLE, DONE: begin
                state_nx = IDLE;
                // DONE accepts a new start exactly as IDLE does.
                if (start_evt) begin
                    width_nx = width_i;
                    space_nx = pulse_spacing_i;
                    npul_nx  = num_pulses_i;
                    if (num_pulses_i == '0 || width_i == '0) begin
                        state_nx = DONE;
                    end else if (delay_i == '0) begin
                        state_nx = HIGH;
                        cnt_nx   = width_load(width_i);
                    end else begin
                        state_nx = DELAY;
                        cnt_nx   = delay_i - DELAY_W'(1);
                    end
                end
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    state_nx = HIGH;
                    cnt_nx   = width_load(width_q);
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q != '0) begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end else if (npul_q == NPULSE_W'(1)) begin
                    state_nx = DONE;
                end else begin
                    state_nx = LOW;
                    cnt_nx   = gap_load(space_q);
                    npul_nx  = npul_q - NPULSE_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_nx = HIGH;
                    cnt_nx   = width_load(width_q);
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort_i && state_q != IDLE) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            npul_q   <= '0;
            width_q  <= '0;
            space_q  <= '0;
            glitch_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cnt_q    <= cnt_nx;
            npul_q   <= npul_nx;
            width_q  <= width_nx;
            space_q  <= space_nx;
            // Outputs are decoded from the next state so they line up with state_q while staying pure flops.
            glitch_o <= (state_nx == HIGH);
            busy_o   <= (state_nx == DELAY) || (state_nx == HIGH) || (state_nx == LOW);
            done_o   <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Scoreboard bench: stimulus pushes expected output edges, a negedge monitor pops and compares them.
module tb_glitch_pulse_gen;

    localparam int K_BR = 0;
    localparam int K_GR = 1;
    localparam int K_GF = 2;
    localparam int K_BF = 3;
    localparam int K_DN = 4;

    typedef struct {
        int kind;
        int t;
    } ev_t;

    ev_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] delay_i = '0;
    logic [7:0]  width_i = '0;
    logic [7:0]  num_pulses_i = '0;
    logic [15:0] pulse_spacing_i = '0;
    logic        pulse_en_i = 1'b0;
    logic        ext_trig_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        glitch_o, busy_o, done_o;
    logic        nx_glitch, nx_busy, nx_done;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int noext_hits = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glitch_pulse_gen #(.EXT_TRIG_EN(1), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .delay_i         (delay_i),
        .width_i         (width_i),
        .num_pulses_i    (num_pulses_i),
        .pulse_spacing_i (pulse_spacing_i),
        .pulse_en_i      (pulse_en_i),
        .ext_trig_i      (ext_trig_i),
        .abort_i         (abort_i),
        .glitch_o        (glitch_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    glitch_pulse_gen #(.EXT_TRIG_EN(0), .SYNC_STAGES(2)) u_noext (
        .clk             (clk),
        .rst             (rst),
        .delay_i         (delay_i),
        .width_i         (width_i),
        .num_pulses_i    (num_pulses_i),
        .pulse_spacing_i (pulse_spacing_i),
        .pulse_en_i      (1'b0),
        .ext_trig_i      (ext_trig_i),
        .abort_i         (1'b0),
        .glitch_o        (nx_glitch),
        .busy_o          (nx_busy),
        .done_o          (nx_done)
    );

    function automatic string kname(input int k);
        case (k)
            K_BR:    return "busy_rise";
            K_GR:    return "glitch_rise";
            K_GF:    return "glitch_fall";
            K_BF:    return "busy_fall";
            K_DN:    return "done";
            default: return "unknown";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int k, input int t);
        ev_t e;
        e.kind = k;
        e.t    = t;
        exp_q.push_back(e);
    endtask

    task automatic push_train(input int T, input int d, input int w, input int n, input int sp);
        int t;
        int gap;
        if (n == 0 || w == 0) begin
            push(K_DN, T + 1);
        end else begin
            gap = (sp == 0) ? 1 : sp;
            push(K_BR, T + 1);
            t = T + 1 + d;
            for (int i = 0; i < n; i++) begin
                push(K_GR, t);
                push(K_GF, t + w);
                if (i < n - 1) t = t + w + gap;
            end
            push(K_BF, t + w);
            push(K_DN, t + w);
        end
    endtask

    task automatic got(input int k, input int t);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s@%0d, required none", kname(k), t);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.t != t) begin
                n_fail++;
                $display("FAIL event_check: got %s@%0d, required %s@%0d", kname(k), t, kname(e.kind), e.t);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge that opens cycle L.
    task automatic at_cycle(input int L);
        while (cyc + 1 < L) @(negedge clk);
    endtask

    task automatic start(input int d, input int w, input int n, input int sp,
                         input bit push_exp, output int T);
        delay_i         = 16'(d);
        width_i         = 8'(w);
        num_pulses_i    = 8'(n);
        pulse_spacing_i = 16'(sp);
        pulse_en_i      = 1'b1;
        T = cyc + 1;
        if (push_exp) push_train(T, d, w, n, sp);
        @(negedge clk);
        pulse_en_i = 1'b0;
    endtask

    initial begin : monitor
        bit pg;
        bit pb;
        int lbl;
        pg = 1'b0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (nx_glitch === 1'b1 || nx_busy === 1'b1 || nx_done === 1'b1) noext_hits++;
            if (mon_en) begin
                lbl = cyc + 1;
                if (busy_o && !pb)   got(K_BR, lbl);
                if (glitch_o && !pg) got(K_GR, lbl);
                if (!glitch_o && pg) got(K_GF, lbl);
                if (!busy_o && pb)   got(K_BF, lbl);
                if (done_o)          got(K_DN, lbl);
                pg = glitch_o;
                pb = busy_o;
            end
        end
    end

    initial begin : stim
        int T;
        int E;
        int t0;
        repeat (3) @(negedge clk);
        chk("reset_glitch", int'(glitch_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(done_o), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        start(5, 3, 2, 4, 1, T);
        at_cycle(T + 8);
        chk("basic_mid_glitch", int'(glitch_o), 1);
        at_cycle(T + 20);

        start(0, 1, 1, 0, 1, T);
        at_cycle(T + 5);

        start(2, 2, 3, 0, 1, T);
        at_cycle(T + 16);

        start(0, 5, 0, 3, 1, T);
        at_cycle(T + 4);
        start(4, 0, 3, 3, 1, T);
        at_cycle(T + 4);

        // Config changes and a second strobe mid-train must not disturb the running train.
        start(100, 2, 1, 0, 1, T);
        at_cycle(T + 5);
        delay_i = 16'd7;
        at_cycle(T + 10);
        pulse_en_i = 1'b1;
        @(negedge clk);
        pulse_en_i = 1'b0;
        at_cycle(T + 50);
        chk("latched_busy", int'(busy_o), 1);
        at_cycle(T + 110);

        // Restart issued in the DONE cycle.
        start(1, 1, 1, 0, 1, T);
        at_cycle(T + 3);
        start(0, 2, 1, 0, 1, T);
        at_cycle(T + 8);

        E = cyc + 1;
        ext_trig_i = 1'b1;
        push_train(E + 2, 0, 2, 1, 0);
        delay_i = 16'd0;
        width_i = 8'd2;
        num_pulses_i = 8'd1;
        pulse_spacing_i = 16'd0;
        at_cycle(E + 20);
        ext_trig_i = 1'b0;
        at_cycle(E + 25);

        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        repeat (3) @(negedge clk);

        T = cyc + 1;
        t0 = T + 4;
        push(K_BR, T + 1);
        push(K_GR, t0);
        push(K_GF, t0 + 2);
        push(K_BF, t0 + 2);
        start(3, 10, 2, 2, 0, T);
        at_cycle(t0 + 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_glitch", int'(glitch_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        at_cycle(t0 + 20);
        start(0, 3, 1, 0, 1, T);
        at_cycle(T + 6);

        T = cyc + 1;
        push(K_BR, T + 1);
        push(K_BF, T + 6);
        start(20, 2, 1, 0, 0, T);
        at_cycle(T + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(busy_o), 0);
        at_cycle(T + 40);
        start(1, 2, 2, 1, 1, T);
        at_cycle(T + 12);

        start(300, 255, 2, 1000, 1, T);
        at_cycle(T + 1830);
        start(2, 1, 255, 0, 1, T);
        at_cycle(T + 520);

        chk("queue_empty", exp_q.size(), 0);
        chk("noext_quiet", noext_hits, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
